mux_nx1_scan: RTL
=================

# mux_nx1_scan

Parametrised, registered N-channel, W-bit multiplexer with two modes: manual select, and auto-scan that time-multiplexes the channels at a programmable rate. Replaces the fixed 1-bit 4:1 combinational mux wherever a registered output or a channel scanner is needed, e.g. for multiplexed display digit driving. Single clock domain, with asynchronous active-high reset.

## Interface
Parameters:
- WIDTH, 1, bits per channel (≥1)
- CHANNELS, 4, number of input channels (2..2^SEL_W)
- SEL_W, 2, select/channel index width
- SCAN_DIV, 4, clock cycles spent on each channel in scan mode (≥1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- data_in  in  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  channel index in manual mode
- mode  in  1  0 = manual, 1 = scan
- hold  in  1  scan mode only: freezes the prescaler and the channel index
- out  out  WIDTH  registered selected data
- ch  out  SEL_W  registered index of the channel currently presented
- tick  out  1  one-cycle pulse; ch advanced in this cycle (scan mode)
- sel_err  out  1  registered; manual sel ≥ CHANNELS

## Operation
- Reset values (asynchronous): out=0, ch=0, tick=0, sel_err=0, prescaler div_cnt=0, mode_q=0.
- Every cycle, out loads the channel selected in the current cycle, so out always lags that selection by one cycle.
- Manual mode (mode=0):
  - If sel < CHANNELS: out ← data_in[sel], ch ← sel, sel_err ← 0.
  - Otherwise: out ← 0, ch holds its value, sel_err ← 1.
  - div_cnt ← 0 and tick ← 0.
- Scan mode (mode=1):
  - out ← data_in[ch], using the current registered ch. sel is ignored and sel_err ← 0.
  - If hold=1: div_cnt and ch are unchanged and tick ← 0. out keeps sampling data_in[ch].
  - If hold=0 and div_cnt = SCAN_DIV−1: div_cnt ← 0, ch ← (ch = CHANNELS−1) ? 0 : ch+1, tick ← 1.
  - If hold=0 otherwise: div_cnt ← div_cnt+1 and tick ← 0.
- Mode switch:
  - mode_q registers mode.
  - The first scan-mode cycle after manual (mode=1, mode_q=0) forces div_cnt ← 0 and does not tick.
  - Scanning resumes from the current ch.
  - Switching scan→manual takes effect in the same cycle. Any pending prescaler count is discarded.
- div_cnt width: clog2(SCAN_DIV), minimum 1 bit.
- SCAN_DIV=1: ch advances every non-hold cycle and tick stays high continuously.
- Channel indices CHANNELS..2^SEL_W−1 are never produced by the scanner.
- An out-of-range manual sel must never reach the data_in part-select; it is gated to 0.

## Timing
- Latency is 1 cycle from data_in, sel or mode to out, ch and sel_err.
- In scan mode:
  - tick is high in the cycle ch changes.
  - out shows the new channel's data one cycle after the tick cycle.
  - Without hold, the tick period is exactly SCAN_DIV cycles and each channel is presented for SCAN_DIV cycles.
- hold has effect in the cycle it is sampled high. Releasing hold resumes counting from the frozen div_cnt.
- Reset asserted mid-scan clears everything immediately, without waiting for clk. After deassertion, the first tick occurs SCAN_DIV cycles later.

## Test plan
Bench settings: WIDTH=4, CHANNELS=3, SEL_W=2, SCAN_DIV=3, data_in={4'hC,4'hB,4'hA}.
- Manual walk: sel=0,1,2 on consecutive cycles -> out=A,B,C one cycle later each; ch=0,1,2; sel_err=0.
- Out-of-range select: sel=3 -> next cycle out=0, sel_err=1, ch holds 2. Then sel=1 -> out=B, sel_err=0.
- Scan from reset: mode=1 -> tick on cycles 3, 6, 9 after entry; ch sequence 1,2,0 (wraps); out=B,C,A one cycle after each tick; each value holds 3 cycles.
- Hold: assert hold for 5 cycles at div_cnt=1 -> no tick and ch frozen. The next tick comes 2 cycles after release. Changing data_in[ch] during hold appears on out 1 cycle later.
- Mode switch: scan at ch=2, switch to manual sel=0 -> out=A next cycle. Back to scan -> first tick 3 cycles later, ch 0→1.
- Async reset mid-scan: pulse reset between edges -> out, ch, tick and sel_err go to 0 immediately. The scan restarts at ch=0 with a tick 3 cycles after release.

Source files
------------

// File: rtl/mux_nx1_scan.sv
// Registered N-channel, W-bit multiplexer with a manual-select mode and an
// auto-scan mode that steps through the channels at a programmable rate.
module mux_nx1_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          ch,
  output logic                      tick,
  output logic                      sel_err
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             mode_q;

  logic [WIDTH-1:0] out_nxt;
  logic [SEL_W-1:0] ch_nxt;
  logic             tick_nxt;
  logic             err_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic             sel_ok;

  // Loop-based lookup only ever touches real channels, so an out-of-range
  // index can never form an illegal part-select; it simply yields zero.
  function automatic logic [WIDTH-1:0] chan_data(
    input logic [CHANNELS*WIDTH-1:0] d,
    input logic [SEL_W-1:0]          idx
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) r = d[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
    return (c == CH_LAST) ? '0 : c + 1'b1;
  endfunction

  always_comb begin
    out_nxt  = out;
    ch_nxt   = ch;
    tick_nxt = 1'b0;
    err_nxt  = 1'b0;
    div_nxt  = div_cnt;
    sel_ok   = ({1'b0, sel} < CH_LIM);

    if (!mode) begin
      out_nxt = sel_ok ? chan_data(data_in, sel) : '0;
      ch_nxt  = sel_ok ? sel : ch;
      err_nxt = !sel_ok;
      div_nxt = '0;
    end else begin
      out_nxt = chan_data(data_in, ch);
      // Entering scan restarts the prescaler so every channel gets a full slot.
      if (!mode_q) begin
        div_nxt = '0;
      end else if (!hold) begin
        if (div_cnt == DIV_LAST) begin
          div_nxt  = '0;
          ch_nxt   = next_ch(ch);
          tick_nxt = 1'b1;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out     <= '0;
      ch      <= '0;
      tick    <= 1'b0;
      sel_err <= 1'b0;
      div_cnt <= '0;
      mode_q  <= 1'b0;
    end else begin
      out     <= out_nxt;
      ch      <= ch_nxt;
      tick    <= tick_nxt;
      sel_err <= err_nxt;
      div_cnt <= div_nxt;
      mode_q  <= mode;
    end
  end

endmodule
